// File: rtl/vx_reset_sequencer_if.sv
// Reset sequencer bundle: per-channel soft-reset requests in, per-channel
// resets, done flag and FSM debug state out.
//
// Signalling: every signal here is a plain level, with no valid/ready
// handshake. soft_reset is sampled on every rising clk edge. reset_o, done and
// dbg_state are registered outputs that change only on rising clk edges.
interface vx_reset_sequencer_if #(
  parameter int N = 1
);
  logic [N-1:0] soft_reset;
  logic [N-1:0] reset_o;
  logic         done;
  logic [1:0]   dbg_state;

  // The sequencer drives the resets. The requester drives the soft-reset lines.
  modport master (
    output soft_reset,
    input  reset_o,
    input  done,
    input  dbg_state
  );

  modport slave (
    input  soft_reset,
    output reset_o,
    output done,
    output dbg_state
  );
endinterface

// File: rtl/vx_reset_sequencer.sv
// vx_reset_sequencer: retimes the global reset through a DEPTH-stage chain. It
// holds all N channel resets for HOLD cycles after the retimed reset falls, then
// releases channel i at t = HOLD + i*STAGGER. done rises once every channel is
// out of reset.
// Optional feature macro RESET_SEQ_SOFT_EN builds the per-channel soft-reset
// pulse logic, which is active only in DONE. Without the macro, soft_reset is
// ignored and done follows the DONE state alone.
module vx_reset_sequencer #(
  parameter int N       = 1,
  parameter int DEPTH   = 1,
  parameter int HOLD    = 0,
  parameter int STAGGER = 0
) (
  input  logic             clk,
  input  logic             reset,
  vx_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Release time of the last channel. The counter is wide enough to hold
  // LAST+1, so it can saturate there.
  localparam int LAST = HOLD + (N - 1) * STAGGER;
  localparam int CW   = $clog2(LAST + 2);

  // Retimed reset. The name is historical: this is the delayed reset, not a
  // next-state value.
  logic reset_d;

  if (DEPTH > 1) begin : g_retime
    logic [DEPTH-2:0] pipe_q;
    logic [DEPTH-2:0] pipe_d;

    // Shift the raw reset along DEPTH-1 unreset stages.
    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = reset;
      for (int i = 1; i < DEPTH - 1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Pipeline stages: data only, no reset.
    always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
    end

    assign reset_d = pipe_q[DEPTH-2];
  end else begin : g_no_retime
    assign reset_d = reset;
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   reset_o_q, reset_o_d;
  logic           done_q, done_d;

`ifdef RESET_SEQ_SOFT_EN
  localparam int SW = $clog2(HOLD + 2);
  logic [SW-1:0]  soft_cnt_q [N];
  logic [SW-1:0]  soft_cnt_d [N];
  logic [N-1:0]   soft_act_d;
`else
  logic unused_soft;
  assign unused_soft = ^bus.soft_reset;
`endif

  // Next-state logic for the release sequence and for soft-reset pulses in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reset_o_d = reset_o_q;
    done_d    = done_q;
`ifdef RESET_SEQ_SOFT_EN
    soft_act_d = '0;
    for (int i = 0; i < N; i++) begin
      soft_cnt_d[i] = soft_cnt_q[i];
    end
`endif
    case (state_q)
      ST_ASSERT, ST_RELEASE: begin
        // cnt_q is 0 on the first edge after the retimed reset falls (t = 0).
        for (int i = 0; i < N; i++) begin
          if (int'(cnt_q) >= HOLD + i * STAGGER) begin
            reset_o_d[i] = 1'b0;
          end
        end
        if (int'(cnt_q) >= LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RELEASE;
        end
        if (cnt_q != CW'(LAST + 1)) begin
          cnt_d = cnt_q + 1'b1;
        end
        done_d = (state_d == ST_DONE);
      end
      ST_DONE: begin
`ifdef RESET_SEQ_SOFT_EN
        // A new request reloads the pulse, so a repeated request extends it.
        for (int i = 0; i < N; i++) begin
          if (bus.soft_reset[i]) begin
            soft_cnt_d[i] = SW'(HOLD + 1);
          end else if (soft_cnt_q[i] != '0) begin
            soft_cnt_d[i] = soft_cnt_q[i] - 1'b1;
          end
          soft_act_d[i] = (soft_cnt_d[i] != '0);
        end
        reset_o_d = soft_act_d;
        done_d    = (soft_act_d == '0);
`else
        reset_o_d = '0;
        done_d    = 1'b1;
`endif
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  // State and output registers. The retimed reset forces ASSERT in any state.
  always_ff @(posedge clk) begin
    if (reset_d) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      reset_o_q <= '1;
      done_q    <= 1'b0;
`ifdef RESET_SEQ_SOFT_EN
      for (int i = 0; i < N; i++) begin
        soft_cnt_q[i] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reset_o_q <= reset_o_d;
      done_q    <= done_d;
`ifdef RESET_SEQ_SOFT_EN
      for (int i = 0; i < N; i++) begin
        soft_cnt_q[i] <= soft_cnt_d[i];
      end
`endif
    end
  end

  assign bus.reset_o   = reset_o_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Bench for vx_reset_sequencer. Two instances run side by side on one clock:
//   dut_a: N=4, DEPTH=3, HOLD=2, STAGGER=3 (staggered release, mid-run reset,
//          soft reset)
//   dut_b: N=4, DEPTH=1, HOLD=0, STAGGER=0 (one-cycle relay)
// Every cycle the driver pushes the expected {done, reset_o} for the coming
// edge. The monitor pops each entry and compares it on the following negedge.
module tb_vx_reset_sequencer;

  localparam int N  = 4;
  localparam int W  = N + 2;   // {care, done, reset_o}
  localparam int DA = 3;
  localparam int HA = 2;
  localparam int SA = 3;
  localparam int DB = 1;
  localparam int HB = 0;
  localparam int SB = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  vx_reset_sequencer_if #(.N(N)) if_a ();
  vx_reset_sequencer_if #(.N(N)) if_b ();

  vx_reset_sequencer #(.N(N), .DEPTH(DA), .HOLD(HA), .STAGGER(SA)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  vx_reset_sequencer #(.N(N), .DEPTH(DB), .HOLD(HB), .STAGGER(SB)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  bit           hist_a[$];
  bit           hist_b[$];
  int           run_a = 0;
  int           run_b = 0;
  int           n_vec = 0;
  int           n_bad = 0;

  // Expected outputs after an edge. rd is the retimed reset at that edge, and
  // run counts consecutive edges with the retimed reset low. Channel i is low
  // once t = run-1 reaches hld + i*stg. Outputs are undefined until the chain
  // is flushed.
  function automatic logic [W-1:0] predict(input int hsize, input int d, input bit rd,
                                           input int run, input int hld, input int stg);
    logic [N-1:0] ro;
    logic         dn;
    int           t;
    if (hsize < d) return '0;
    if (rd) return {1'b1, 1'b0, {N{1'b1}}};
    t = run - 1;
    for (int i = 0; i < N; i++) begin
      ro[i] = !(t >= hld + i * stg);
    end
    dn = (t >= hld + (N - 1) * stg);
    return {1'b1, dn, ro};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit ra, input bit rb, input logic [N-1:0] sa,
                      input bit ovr, input logic [N:0] ovr_a);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    bit           rd;
    @(negedge clk);
    #1;
    rst_a = ra;
    rst_b = rb;
    if_a.soft_reset = sa;

    hist_a.push_back(ra);
    rd = 1'b1;
    if (hist_a.size() >= DA) begin
      rd = hist_a[hist_a.size() - DA];
      run_a = rd ? 0 : run_a + 1;
    end
    ea = predict(hist_a.size(), DA, rd, run_a, HA, SA);
    if (ovr) ea = {1'b1, ovr_a};
    exp_a_q.push_back(ea);

    hist_b.push_back(rb);
    rd = 1'b1;
    if (hist_b.size() >= DB) begin
      rd = hist_b[hist_b.size() - DB];
      run_b = rd ? 0 : run_b + 1;
    end
    eb = predict(hist_b.size(), DB, rd, run_b, HB, SB);
    exp_b_q.push_back(eb);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [W-1:0] e, input logic [N:0] act);
    if (e[W-1]) begin
      n_vec++;
      if (act !== e[N:0]) begin
        n_bad++;
        $display("FAIL %s t=%0t {done,reset_o} got %b expected %b", name, $time, act, e[N:0]);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_a_q.size() > 0) check("chan_a", exp_a_q.pop_front(), {if_a.done, if_a.reset_o});
      if (exp_b_q.size() > 0) check("chan_b", exp_b_q.pop_front(), {if_b.done, if_b.reset_o});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.soft_reset = '0;
    if_b.soft_reset = '0;

    // Power-up reset, then the full staggered release on a and the relay on b.
    repeat (6) step(1'b1, 1'b1, 4'b0000, 1'b0, '0);
    repeat (16) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);

    // One-cycle reset pulse on b: all ones after the rise, all clear after the fall.
    step(1'b0, 1'b1, 4'b0000, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);

`ifdef RESET_SEQ_SOFT_EN
    // A single soft request on channel 2 gives a 3-cycle pulse with done low.
    step(1'b0, 1'b0, 4'b0100, 1'b1, {1'b0, 4'b0100});
    step(1'b0, 1'b0, 4'b0000, 1'b1, {1'b0, 4'b0100});
    step(1'b0, 1'b0, 4'b0000, 1'b1, {1'b0, 4'b0100});
    repeat (2) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
    // Two requests on channel 1, two cycles apart, give a 5-cycle pulse.
    step(1'b0, 1'b0, 4'b0010, 1'b1, {1'b0, 4'b0010});
    step(1'b0, 1'b0, 4'b0000, 1'b1, {1'b0, 4'b0010});
    step(1'b0, 1'b0, 4'b0010, 1'b1, {1'b0, 4'b0010});
    step(1'b0, 1'b0, 4'b0000, 1'b1, {1'b0, 4'b0010});
    step(1'b0, 1'b0, 4'b0000, 1'b1, {1'b0, 4'b0010});
    repeat (2) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
`else
    // Without the feature, soft requests in DONE have no effect.
    step(1'b0, 1'b0, 4'b1111, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
    step(1'b0, 1'b0, 4'b0010, 1'b0, '0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
    step(1'b0, 1'b0, 4'b0010, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
`endif

    // Reset a from DONE, let it reach t=3, then reassert it so the retimed
    // reset is high at t=4. Channel 0 has already released by then.
    repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0, '0);
    repeat (4) step(1'b0, 1'b0, 4'b0000, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0, '0);

    // Full restart from t=0. The soft request at t=3 (during RELEASE) is ignored.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, (i == 5) ? 4'b0010 : 4'b0000, 1'b0, '0);
    end

    // Drain the scoreboard.
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain entries left a=%0d b=%0d expected 0", exp_a_q.size(), exp_b_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_reset_sequencer.md
Name: VX_reset_sequencer

Overview:
Reset distribution relay for N downstream domains (cores, caches, memory interface). It retimes the global reset through a DEPTH-stage register chain and applies a common post-reset hold. It then releases the N outputs staggered in time, to limit simultaneous wake-up and power surge. It also provides per-channel soft-reset pulses and a done flag once every channel is out of reset.

Parameters:
N, 1, number of reset output channels (≥1)
DEPTH, 1, total register stages on the assert path, output register included (≥1)
HOLD, 0, extra cycles all outputs stay asserted after the retimed reset falls; also sets soft-reset pulse length
STAGGER, 0, cycles between release of channel i and channel i+1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
soft_reset  input  N  per-channel soft-reset request, sampled each cycle
reset_o  output  N  per-channel reset, active-high, registered
done  output  1  high when all reset_o bits are low and the sequencer is idle

Behaviour:
- Single clock, clk. Reset is synchronous, active-high, named reset.
- Retiming: reset passes through DEPTH-1 unreset pipeline registers, giving reset_d (DEPTH=1: reset_d = reset). All control and output registers are driven from reset_d.
- Assert latency: reset rising at edge k gives reset_o = all-ones and done = 0 after edge k+DEPTH-1. Reset must be held at least DEPTH+1 cycles at power-up to flush X from the chain.
- Reset values while reset_d = 1: reset_o = {N{1}}, done = 0, state = ASSERT, counter = 0, soft counters = 0.
- FSM states: ASSERT, RELEASE, DONE.
  - ASSERT → RELEASE on the first edge with reset_d = 0; that edge is t = 0. The counter increments by 1 per edge in RELEASE.
  - Channel i is cleared at edge t = HOLD + i*STAGGER and stays low.
  - The edge clearing channel N-1 also moves state to DONE.
  - Counter width is $clog2(HOLD+(N-1)*STAGGER+2) and the counter never wraps (saturates).
- Equivalence: with DEPTH=1, HOLD=0, STAGGER=0 all channels release on the edge after reset falls (1-cycle relay).
- Simultaneous release: STAGGER=0 releases all channels on the same edge.
- Reset mid-operation: reset_d = 1 in any state forces ASSERT and all-ones reset_o on that edge, and clears counters. The sequence restarts from t = 0 on the next fall.
- done: registered; 1 iff state = DONE and no soft reset is active. It goes high on the same edge the last channel releases (or the last soft pulse ends).
- Soft reset (state DONE only):
  - soft_reset[i] = 1 at an edge loads a per-channel counter with HOLD+1 and sets reset_o[i] on that edge.
  - reset_o[i] stays high for exactly HOLD+1 cycles after the last sampled request.
  - A request while the pulse is active reloads the counter, extending the pulse.
- soft_reset is ignored in ASSERT and RELEASE.
- Multiple channels may be soft-reset independently and concurrently.

Optional Feature:
- Macro: RESET_SEQ_SOFT_EN.
- Defined: the soft-reset logic above is built.
- Undefined:
  - Soft-reset counters are not instantiated.
  - The soft_reset port remains but is marked unused and has no effect.
  - done = (state == DONE).

Test Plan:
- N=4, DEPTH=3, HOLD=2, STAGGER=3; reset high 6 cycles, fall at edge k → reset_o[0..3] clear at edges k+2+2, k+2+5, k+2+8, k+2+11; done high with the last release.
- N=4, DEPTH=1, HOLD=0, STAGGER=0; reset pulse → reset_o 4'b1111 one edge after rise, 4'b0000 one edge after fall, done=1 together.
- Same as the first case, but reset reasserted at t=4 (channel 0 already released) → reset_o back to 4'b1111 after DEPTH-1 edges, done=0; full sequence restarts from t=0 on the next fall.
- RESET_SEQ_SOFT_EN, N=4, HOLD=2, state DONE; soft_reset=4'b0100 for 1 cycle → reset_o=4'b0100 for exactly 3 cycles, done=0 during them, then done=1.
- RESET_SEQ_SOFT_EN; soft_reset[1] pulsed during RELEASE → ignored. Pulsed twice in DONE 2 cycles apart with HOLD=2 → reset_o[1] high 5 cycles.
- RESET_SEQ_SOFT_EN undefined; soft_reset=4'b1111 in DONE → reset_o stays 0, done stays 1.
